// File: rtl/bip_pkg.sv
// Shared BIP definitions: instruction layout, opcode set, loader error codes and states.
// Used by the program loader and by the instruction decoder.
package bip_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 11;
  localparam int INSTR_W   = 16;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;
  localparam logic [OPCODE_W-1:0] OP_MAX  = 5'd7;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ld_state_e;

  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/bip_program_loader.sv
// Streams bytes into 16-bit BIP instructions and writes legal ones into program memory
// from address 0, holding the CPU off until a HALT is written.
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MEM_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MEM_DEPTH - 1);

  ld_state_e           state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [INSTR_W-1:0]  word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    word       = {hi_q, rx_data};

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HI;
          cnt_d      = '0;
          err_code_d = ERR_NONE;
        end
      end
      ST_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (rx_valid) begin
          // Illegal words are never presented to memory; the address/data bus keeps the last write.
          if (!opcode_legal(word[INSTR_W-1 -: OPCODE_W])) begin
            state_d    = ST_ERR;
            err_code_d = ERR_ILLEGAL;
          end else begin
            addr_d  = cnt_q[ADDR_W-1:0];
            data_d  = word;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        // HALT wins over overflow, so a program that exactly fills memory still completes.
        if (data_q[INSTR_W-1 -: OPCODE_W] == OP_HLT) begin
          state_d = ST_DONE;
        end else if (cnt_q == LAST_IDX) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVERFLOW;
        end else begin
          state_d = ST_HI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_ready    = (state_q == ST_HI) || (state_q == ST_LO);
  assign mem_we      = (state_q == ST_WRITE);
  assign busy        = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_WRITE);
  // An aborted load keeps the CPU parked so a partial program never runs.
  assign cpu_hold    = busy || (state_q == ST_ERR);
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERR);
  assign error_code  = err_code_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed bench for bip_program_loader: table of whole-load scenarios plus hand-written
// sequences for start-while-busy, restart from DONE and reset in the middle of a word.
module tb_bip_program_loader;

  localparam int ADDR_W    = 11;
  localparam int MEM_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_we;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [1:0]        error_code;
  logic [ADDR_W:0]   instr_count;

  bip_program_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error),
    .error_code(error_code), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [26:0] wq[$];
  int          viol = 0;
  logic        prev_we = 1'b0;

  // Write log and handshake protocol watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_data});
    if (mem_we && rx_ready) viol = viol + 1;
    if (mem_we && prev_we) viol = viol + 1;
    prev_we = mem_we;
  end

  typedef struct {
    string       nm;
    int          nb;
    logic [63:0] bytes;
    bit          bp;
    int          nw;
    logic [63:0] words;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_cnt;
    logic        exp_hold;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (rx_ready) ok = 1;
      @(negedge clk);
      if (ok) break;
    end
    rx_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_write(input string nm, input int idx, input logic [10:0] a, input logic [15:0] d);
    if (idx < wq.size()) begin
      chk({nm, "_addr"}, 32'(wq[idx][26:16]), 32'(a));
      chk({nm, "_data"}, 32'(wq[idx][15:0]), 32'(d));
    end else begin
      chk({nm, "_missing"}, 32'(wq.size()), 32'(idx + 1));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int rdy;
    wq.delete();
    pulse_start();
    chk({v.nm, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.nb; i++) begin
      if (v.bp && i > 0) @(negedge clk);
      send_byte(v.bytes[63-8*i -: 8]);
    end
    wait_idle();
    @(negedge clk);
    chk({v.nm, "_nwrites"}, 32'(wq.size()), 32'(v.nw));
    for (int j = 0; j < v.nw; j++)
      chk_write(v.nm, j, 11'(j), v.words[63-16*j -: 16]);
    chk({v.nm, "_done"}, 32'(done), 32'(v.exp_done));
    chk({v.nm, "_error"}, 32'(error), 32'(v.exp_err));
    chk({v.nm, "_code"}, 32'(error_code), 32'(v.exp_code));
    chk({v.nm, "_count"}, 32'(instr_count), 32'(v.exp_cnt));
    chk({v.nm, "_busy"}, 32'(busy), 32'd0);
    chk({v.nm, "_hold"}, 32'(cpu_hold), 32'(v.exp_hold));
    if (v.exp_err) begin
      rdy = 0;
      rx_valid = 1'b1;
      rx_data  = 8'h18;
      for (int k = 0; k < 4; k++) begin
        if (rx_ready) rdy++;
        @(negedge clk);
      end
      rx_valid = 1'b0;
      chk({v.nm, "_ready_after_err"}, 32'(rdy), 32'd0);
      chk({v.nm, "_nwrites_after_err"}, 32'(wq.size()), 32'(v.nw));
    end
  endtask

  initial begin
    vecs[0] = '{nm:"normal", nb:6, bytes:64'h1805_2803_0000_0000, bp:0, nw:3,
                words:64'h1805_2803_0000_0000, exp_done:1, exp_err:0, exp_code:2'd0,
                exp_cnt:3, exp_hold:0};
    vecs[1] = '{nm:"backpressure", nb:6, bytes:64'h1805_2803_0000_0000, bp:1, nw:3,
                words:64'h1805_2803_0000_0000, exp_done:1, exp_err:0, exp_code:2'd0,
                exp_cnt:3, exp_hold:0};
    vecs[2] = '{nm:"illegal", nb:4, bytes:64'h1805_4001_0000_0000, bp:0, nw:1,
                words:64'h1805_0000_0000_0000, exp_done:0, exp_err:1, exp_code:2'd1,
                exp_cnt:1, exp_hold:1};
    vecs[3] = '{nm:"overflow", nb:8, bytes:64'h1801_1801_1801_1801, bp:0, nw:4,
                words:64'h1801_1801_1801_1801, exp_done:0, exp_err:1, exp_code:2'd2,
                exp_cnt:4, exp_hold:1};

    rst = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done_err", 32'({done, error, error_code}), 32'd0);
    chk("rst_addr_data", 32'({mem_addr, mem_data}), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_writes", 32'(wq.size()), 32'd0);

    for (int t = 0; t < 4; t++) run_vec(vecs[t]);

    // Reset in the middle of a word, with a low byte being offered.
    wq.delete();
    pulse_start();
    send_byte(8'h18);
    chk("midlo_state_ready", 32'(rx_ready), 32'd1);
    rx_data = 8'h05; rx_valid = 1'b1; rst = 1'b0;
    #1;
    chk("midlo_busy", 32'(busy), 32'd0);
    chk("midlo_ready", 32'(rx_ready), 32'd0);
    chk("midlo_hold", 32'(cpu_hold), 32'd0);
    chk("midlo_flags", 32'({done, error, error_code}), 32'd0);
    chk("midlo_addr_data", 32'({mem_addr, mem_data}), 32'd0);
    chk("midlo_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    chk("midlo_no_we", 32'(wq.size()), 32'd0);
    pulse_start();
    send_byte(8'h28); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    @(negedge clk);
    chk("after_rst_nwrites", 32'(wq.size()), 32'd2);
    chk_write("after_rst_w0", 0, 11'd0, 16'h2803);
    chk_write("after_rst_w1", 1, 11'd1, 16'h0000);
    chk("after_rst_done", 32'(done), 32'd1);

    // start pulsed while the loader waits for a low byte.
    wq.delete();
    pulse_start();
    send_byte(8'h18);
    pulse_start();
    chk("start_in_lo_busy", 32'(busy), 32'd1);
    chk("start_in_lo_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    @(negedge clk);
    chk("start_in_lo_nwrites", 32'(wq.size()), 32'd2);
    chk_write("start_in_lo_w0", 0, 11'd0, 16'h1805);
    chk_write("start_in_lo_w1", 1, 11'd1, 16'h0000);
    chk("start_in_lo_done", 32'(done), 32'd1);
    chk("start_in_lo_count", 32'(instr_count), 32'd2);

    // Restart from DONE clears status and begins again at address 0.
    wq.delete();
    pulse_start();
    chk("restart_done_clear", 32'(done), 32'd0);
    chk("restart_count_clear", 32'(instr_count), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    send_byte(8'h30); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    @(negedge clk);
    chk("restart_nwrites", 32'(wq.size()), 32'd2);
    chk_write("restart_w0", 0, 11'd0, 16'h3007);
    chk_write("restart_w1", 1, 11'd1, 16'h0000);
    chk("restart_count", 32'(instr_count), 32'd2);

    chk("protocol_violations", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
